// File: rtl/dmi_core_reg_responder.sv
// Core-domain DMI register responder: acks accepted requests one cycle later, withholds ack on reject.
// Optional rejected-request counter at 7'h12 is built when DMI_RESP_ERRCNT_EN is defined.
module dmi_core_reg_responder #(
    parameter int unsigned   NDATA     = 4,
    parameter int unsigned   AW        = 7,
    parameter logic [AW-1:0] DATA_BASE = 7'h04
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        reg_en,
    input  logic        reg_wr_en,
    input  logic [31:0] c_wr_addr,
    input  logic [31:0] c_wr_data,
    output logic [31:0] c_rd_data,
    output logic        c_rd_ack,
    output logic        busy
);
    localparam int unsigned   IW        = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam logic [AW-1:0] ADDR_CTRL = AW'(7'h10);
    localparam logic [AW-1:0] ADDR_STAT = AW'(7'h11);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q [NDATA];
    logic [31:0] data_d [NDATA];
    logic [7:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  done_cnt_q, done_cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [AW-1:0] addr_s, off_s;
    logic          hi_zero_s, is_data_s, is_ctrl_s, is_stat_s, is_err_s;
    logic          mapped_s, reject_s, accept_s, go_s, busy_s;
    logic [31:0]   rd_val_s;

    assign addr_s    = c_wr_addr[AW-1:0];
    assign off_s     = addr_s - DATA_BASE;
    assign hi_zero_s = (c_wr_addr[31:AW] == '0);
    assign is_data_s = hi_zero_s && (addr_s >= DATA_BASE) && (off_s < AW'(NDATA));
    assign is_ctrl_s = hi_zero_s && (addr_s == ADDR_CTRL);
    assign is_stat_s = hi_zero_s && (addr_s == ADDR_STAT);
`ifdef DMI_RESP_ERRCNT_EN
    assign is_err_s  = hi_zero_s && (addr_s == AW'(7'h12));
`else
    assign is_err_s  = 1'b0;
`endif
    assign mapped_s  = is_data_s || is_ctrl_s || is_stat_s || is_err_s;
    // Busy only blocks writes that could disturb the running operation; reads always pass.
    assign reject_s  = reg_en && (!mapped_s || (busy_s && reg_wr_en && (is_data_s || is_ctrl_s)));
    assign accept_s  = reg_en && !reject_s;
    assign go_s      = accept_s && reg_wr_en && is_ctrl_s && c_wr_data[0];

`ifdef DMI_RESP_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;

    // Saturating reject counter, cleared by any accepted write to its address.
    always_comb begin
        errcnt_d = errcnt_q;
        if (accept_s && reg_wr_en && is_err_s) begin
            errcnt_d = 16'h0000;
        end else if (reject_s && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'h0001;
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // Reject counter register.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            errcnt_q <= 16'h0000;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end
`endif

    // Read mux over the pre-edge register values.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (is_data_s) begin
            rd_val_s = data_q[off_s[IW-1:0]];
        end else if (is_ctrl_s) begin
            rd_val_s = {16'h0000, ctrl_cnt_q, 8'h00};
        end else if (is_stat_s) begin
            rd_val_s = {16'h0000, done_cnt_q, 7'h00, busy_s};
`ifdef DMI_RESP_ERRCNT_EN
        end else if (is_err_s) begin
            rd_val_s = {16'h0000, errcnt_q};
`endif
        end else begin
            rd_val_s = 32'h0000_0000;
        end
    end

    // FSM state register.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a zero count completes immediately without entering BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_s && (c_wr_data[15:8] != 8'h00)) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (rem_q == 8'h01) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_q)
            ST_BUSY: busy_s = 1'b1;
            ST_IDLE: busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Datapath next state: registers, countdown, completion counter and response.
    always_comb begin
        data_d     = data_q;
        ctrl_cnt_d = ctrl_cnt_q;
        rem_d      = rem_q;
        done_cnt_d = done_cnt_q;
        if (accept_s && reg_wr_en && is_data_s) begin
            data_d[off_s[IW-1:0]] = c_wr_data;
        end else begin
            data_d = data_q;
        end
        if (accept_s && reg_wr_en && is_ctrl_s) begin
            ctrl_cnt_d = c_wr_data[15:8];
        end else begin
            ctrl_cnt_d = ctrl_cnt_q;
        end
        if (go_s) begin
            rem_d = c_wr_data[15:8];
            if (c_wr_data[15:8] == 8'h00) begin
                done_cnt_d = done_cnt_q + 8'h01;
            end else begin
                done_cnt_d = done_cnt_q;
            end
        end else if (busy_s) begin
            rem_d = rem_q - 8'h01;
            if (rem_q == 8'h01) begin
                done_cnt_d = done_cnt_q + 8'h01;
            end else begin
                done_cnt_d = done_cnt_q;
            end
        end else begin
            rem_d      = rem_q;
            done_cnt_d = done_cnt_q;
        end
        ack_d     = accept_s;
        rd_data_d = (accept_s && !reg_wr_en) ? rd_val_s : 32'h0000_0000;
    end

    // Datapath registers; reset also drops the request sampled on the same edge.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            for (int i = 0; i < NDATA; i++) begin
                data_q[i] <= 32'h0000_0000;
            end
            ctrl_cnt_q <= 8'h00;
            rem_q      <= 8'h00;
            done_cnt_q <= 8'h00;
            ack_q      <= 1'b0;
            rd_data_q  <= 32'h0000_0000;
        end else begin
            data_q     <= data_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            rem_q      <= rem_d;
            done_cnt_q <= done_cnt_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign c_rd_ack  = ack_q;
    assign c_rd_data = rd_data_q;
    assign busy      = busy_s;
endmodule

// File: tb/tb_dmi_core_reg_responder.sv
// Scoreboard bench for dmi_core_reg_responder; expectations come from a behavioural model.
module tb_dmi_core_reg_responder;
    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        reg_en = 1'b0;
    logic        reg_wr_en = 1'b0;
    logic [31:0] c_wr_addr = 32'h0;
    logic [31:0] c_wr_data = 32'h0;
    logic [31:0] c_rd_data;
    logic        c_rd_ack;
    logic        busy;

    dmi_core_reg_responder dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .reg_en   (reg_en),
        .reg_wr_en(reg_wr_en),
        .c_wr_addr(c_wr_addr),
        .c_wr_data(c_wr_data),
        .c_rd_data(c_rd_data),
        .c_rd_ack (c_rd_ack),
        .busy     (busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        string       tag;
        logic        ack;
        logic [31:0] data;
        logic        bsy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_data [4];
    logic [7:0]  m_cnt, m_rem, m_done;
    logic        m_busy;
    logic [15:0] m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge and push the expected post-edge response.
    task automatic cyc(input string tag, input logic rst, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [6:0]  a;
        logic        hz, isd, isc, iss, ise, mapped, rej, acc;
        logic [31:0] rv;
        @(negedge core_clk);
        core_rst = rst; reg_en = en; reg_wr_en = wr; c_wr_addr = addr; c_wr_data = wd;
        e.tag = tag;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
            m_cnt = 8'h0; m_rem = 8'h0; m_done = 8'h0; m_busy = 1'b0; m_err = 16'h0;
            e.ack = 1'b0; e.data = 32'h0; e.bsy = 1'b0;
        end else begin
            a   = addr[6:0];
            hz  = (addr[31:7] == 25'h0);
            isd = hz && (a >= 7'h04) && (a <= 7'h07);
            isc = hz && (a == 7'h10);
            iss = hz && (a == 7'h11);
`ifdef DMI_RESP_ERRCNT_EN
            ise = hz && (a == 7'h12);
`else
            ise = 1'b0;
`endif
            mapped = isd || isc || iss || ise;
            rej = en && (!mapped || (m_busy && wr && (isd || isc)));
            acc = en && !rej;
            rv = 32'h0;
            if (isd) rv = m_data[a - 7'h04];
            if (isc) rv = {16'h0, m_cnt, 8'h0};
            if (iss) rv = {16'h0, m_done, 7'h0, m_busy};
            if (ise) rv = {16'h0, m_err};
            e.ack  = acc;
            e.data = (acc && !wr) ? rv : 32'h0;
            if (m_busy) begin
                if (m_rem == 8'd1) begin m_busy = 1'b0; m_done = m_done + 8'd1; end
                m_rem = m_rem - 8'd1;
            end
            if (acc && wr) begin
                if (isd) m_data[a - 7'h04] = wd;
                if (isc) begin
                    m_cnt = wd[15:8];
                    if (wd[0]) begin
                        m_rem = wd[15:8];
                        if (wd[15:8] == 8'd0) m_done = m_done + 8'd1;
                        else m_busy = 1'b1;
                    end
                end
                if (ise) m_err = 16'h0;
            end
            if (rej && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            e.bsy = m_busy;
        end
        exp_q.push_back(e);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr);
        cyc(tag, 1'b0, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        cyc(tag, 1'b0, 1'b1, 1'b1, addr, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Compare DUT outputs shortly after each edge against the queued expectation.
    always @(posedge core_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, ".ack"}, {31'h0, c_rd_ack}, {31'h0, e.ack});
            check_val({e.tag, ".busy"}, {31'h0, busy}, {31'h0, e.bsy});
            if (e.ack) check_val({e.tag, ".data"}, c_rd_data, e.data);
        end
    end

    initial begin
        logic [31:0] ad, wd;
        cyc("rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("rst", 1'b1, 1'b1, 1'b1, 32'h4, 32'h5);
        // T1 / T2
        rd("t1_rd_d0", 32'h4);
        wr("t2_wr_d2", 32'h6, 32'hDEAD_BEEF);
        rd("t2_rd_d2", 32'h6);
        // T3: busy window, rejected data write, status after completion
        wr("t3_go", 32'h10, 32'h0000_0301);
        wr("t3_wr_d0_busy", 32'h4, 32'h1111_1111);
        rd("t3_rd_ctrl_busy", 32'h10);
        idle(1);
        rd("t3_rd_stat_edge", 32'h11);
        idle(1);
        rd("t3_rd_stat", 32'h11);
        rd("t3_rd_d0", 32'h4);
        // T4: unmapped addresses
        rd("t4_rd_7f", 32'h7F);
        rd("t4_rd_hi", 32'h0001_0004);
        rd("t4_rd_12", 32'h12);
        // T5: 256 zero-count GOs wrap DONE_CNT, then reset mid-operation
        for (int i = 0; i < 256; i++) wr("t5_go0", 32'h10, 32'h0000_0001);
        rd("t5_rd_stat", 32'h11);
        wr("t5_go8", 32'h10, 32'h0000_0801);
        idle(2);
        cyc("t5_rst_busy", 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        rd("t5_rd_stat_after", 32'h11);
        // T6: reject counter clear (or unmapped when the counter is absent)
        rd("t6_rej", 32'h7F);
        rd("t6_rej", 32'h13);
        rd("t6_rej", 32'h0000_0100);
        rd("t6_rd_12", 32'h12);
        wr("t6_wr_12", 32'h12, 32'hFFFF_FFFF);
        rd("t6_rd_12_clr", 32'h12);
        // Random mix, including requests on busy completion edges
        for (int i = 0; i < 300; i++) begin
            ad = 32'($urandom_range(3, 19));
            wd = $urandom;
            if (ad == 32'h10) wd = wd & 32'h0000_0301;
            if ($urandom_range(0, 9) == 0) ad = ad | 32'h0000_0080;
            cyc("rnd", 1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ad, wd);
        end
        idle(2);
        @(posedge core_clk);
        #3;
        check_val("drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
